idct_coef_feeder: RTL

IDCT_COEF_FEEDER -- requirements
Module: idct_coef_feeder

---
 rtl/idct_coef_feeder.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/idct_coef_feeder.sv
// idct_coef_feeder: dequantises a zigzag-ordered coefficient stream, reorders
// it into raster order in a ping-pong pair of 64-entry banks, and emits each
// completed block as 8 rows of 8 coefficients to the row-IDCT.
//   clk, reset      : clock, synchronous active-low reset
//   in_valid/ready  : coefficient handshake, in_coef signed, zigzag order
//   q_we/addr/data  : quantiser table write port (zigzag index)
//   data_rdy        : one row valid on im0..im7 (im0 = column 0)
//   row_idx         : row number of the current output row
//   blk_last        : high with data_rdy on row 7
module idct_coef_feeder #(
   parameter int unsigned COEF_W = 12,
   parameter int unsigned Q_W    = 8,
   parameter int unsigned OUT_W  = 17
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [COEF_W-1:0]       in_coef,
   input  logic                    q_we,
   input  logic [5:0]              q_addr,
   input  logic [Q_W-1:0]          q_data,
   output logic                    data_rdy,
   output logic signed [OUT_W-1:0] im0,
   output logic signed [OUT_W-1:0] im1,
   output logic signed [OUT_W-1:0] im2,
   output logic signed [OUT_W-1:0] im3,
   output logic signed [OUT_W-1:0] im4,
   output logic signed [OUT_W-1:0] im5,
   output logic signed [OUT_W-1:0] im6,
   output logic signed [OUT_W-1:0] im7,
   output logic [2:0]              row_idx,
   output logic                    blk_last
);

   localparam int unsigned PROD_W = COEF_W + Q_W + 1;
   localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [PROD_W-1:0] SAT_MIN = PROD_W'(-(2 ** (OUT_W - 1)));

   // Zigzag beat index -> raster position
   localparam logic [5:0] ZZ [64] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                  state, state_d;
   logic [5:0]              k, k_d;
   logic [2:0]              row_cnt, row_d;
   logic [1:0]              full, full_d;
   logic                    wr_bank, wr_d;
   logic                    rd_bank, rd_d;
   logic                    data_rdy_d, blk_last_d, in_ready_d, load_im;
   logic [2:0]              row_idx_d;
   logic                    accept;

   logic [Q_W-1:0]          qtab [64];
   logic [OUT_W-1:0]        mem  [128];
   logic [OUT_W-1:0]        rd_row [8];
   logic [OUT_W-1:0]        im_q [8];

   logic signed [PROD_W-1:0] coef_ext, q_ext, prod;
   logic [OUT_W-1:0]         sat_val;

   assign accept = in_valid & in_ready & reset;

   // Signed product with zero-extended quantiser entry, then clamp to OUT_W
   assign coef_ext = PROD_W'($signed(in_coef));
   assign q_ext    = PROD_W'({1'b0, qtab[k]});
   assign prod     = coef_ext * q_ext;

   always_comb begin
      if (prod > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
      else if (prod < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
      else                     sat_val = prod[OUT_W-1:0];
   end

   // Quantiser table, survives reset
   always_ff @(posedge clk) begin
      if (q_we) qtab[q_addr] <= q_data;
   end

   // Coefficient banks; bank select is the MSB of the address
   always_ff @(posedge clk) begin
      if (accept) mem[{wr_bank, ZZ[k]}] <= sat_val;
   end

   always_comb begin
      for (int c = 0; c < 8; c++) rd_row[c] = mem[{rd_bank, row_cnt, 3'(c)}];
   end

   // Fill bookkeeping and read FSM next-state
   always_comb begin
      state_d    = state;
      k_d        = k;
      row_d      = row_cnt;
      full_d     = full;
      wr_d       = wr_bank;
      rd_d       = rd_bank;
      data_rdy_d = 1'b0;
      blk_last_d = blk_last;
      row_idx_d  = row_idx;
      load_im    = 1'b0;

      if (accept) begin
         k_d = 6'(k + 6'd1);
         if (k == 6'd63) begin
            full_d[wr_bank] = 1'b1;
            wr_d            = ~wr_bank;
         end
      end

      case (state)
         IDLE: begin
            if (full[rd_bank]) begin
               state_d = EMIT;
               row_d   = 3'd0;
            end
         end
         EMIT: begin
            data_rdy_d = 1'b1;
            row_idx_d  = row_cnt;
            blk_last_d = (row_cnt == 3'd7);
            load_im    = 1'b1;
            row_d      = 3'(row_cnt + 3'd1);
            if (row_cnt == 3'd7) begin
               full_d[rd_bank] = 1'b0;
               rd_d            = ~rd_bank;
               // A fill landing on this same edge still counts: no gap cycle
               state_d         = full_d[~rd_bank] ? EMIT : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      in_ready_d = ~full_d[wr_d];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         k        <= 6'd0;
         row_cnt  <= 3'd0;
         full     <= 2'b00;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         data_rdy <= 1'b0;
         blk_last <= 1'b0;
         row_idx  <= 3'd0;
         in_ready <= 1'b1;
         for (int c = 0; c < 8; c++) im_q[c] <= '0;
      end else begin
         state    <= state_d;
         k        <= k_d;
         row_cnt  <= row_d;
         full     <= full_d;
         wr_bank  <= wr_d;
         rd_bank  <= rd_d;
         data_rdy <= data_rdy_d;
         blk_last <= blk_last_d;
         row_idx  <= row_idx_d;
         in_ready <= in_ready_d;
         if (load_im) begin
            for (int c = 0; c < 8; c++) im_q[c] <= rd_row[c];
         end
      end
   end

   assign im0 = im_q[0];
   assign im1 = im_q[1];
   assign im2 = im_q[2];
   assign im3 = im_q[3];
   assign im4 = im_q[4];
   assign im5 = im_q[5];
   assign im6 = im_q[6];
   assign im7 = im_q[7];

endmodule
